// File: rtl/hazard_ctrl_pipe.sv
// Control-path pipeline (ID/EX, EX/MEM, MEM/WB) for the pipelined RISC-V core,
// with load-use stall, branch/jump flush, operand forwarding and perf counters.
module hazard_ctrl_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             JALRSrcD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             BranchTakenE,
    output logic             JALRSrcE,
    output logic             ALUSrcE,
    output logic             MemWriteE,
    output logic [2:0]       ALUControlE,
    output logic             PCSrcE,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcW,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic [CNT_W-1:0] RetireCount,
    output logic [CNT_W-1:0] StallCount
);

    // ID/EX state (stage p0)
    logic       vld_p0;
    logic       jump_p0;
    logic       branch_p0;
    logic       jalrsrc_p0;
    logic       memwrite_p0;
    logic       alusrc_p0;
    logic       regwrite_p0;
    logic [1:0] resultsrc_p0;
    logic [2:0] aluctl_p0;
    logic [4:0] rs1_p0;
    logic [4:0] rs2_p0;
    logic [4:0] rd_p0;

    // EX/MEM state (stage p1)
    logic       vld_p1;
    logic       memwrite_p1;
    logic       regwrite_p1;
    logic [1:0] resultsrc_p1;
    logic [4:0] rd_p1;

    // MEM/WB state (stage p2)
    logic       vld_p2;
    logic       regwrite_p2;
    logic [1:0] resultsrc_p2;
    logic [4:0] rd_p2;

    logic             pcsrc;
    logic             lwstall;
    logic             flushe;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // MEM beats WB so the youngest producer wins; x0 is never a producer.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       regwrite_m,
        input logic [4:0] rd_m,
        input logic       regwrite_w,
        input logic [4:0] rd_w
    );
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign pcsrc   = jump_p0 | (branch_p0 & BranchTakenE);
    assign lwstall = (resultsrc_p0 == 2'b01) && (rd_p0 != 5'd0)
                     && ((rd_p0 == Rs1D) || (rd_p0 == Rs2D))
                     && ValidD && !pcsrc;
    assign flushe  = lwstall | pcsrc;

    assign StallF      = lwstall;
    assign StallD      = lwstall;
    assign FlushD      = pcsrc;
    assign PCSrcE      = pcsrc;
    assign ForwardAE   = fwd_sel(rs1_p0, regwrite_p1, rd_p1, regwrite_p2, rd_p2);
    assign ForwardBE   = fwd_sel(rs2_p0, regwrite_p1, rd_p1, regwrite_p2, rd_p2);
    assign JALRSrcE    = jalrsrc_p0;
    assign ALUSrcE     = alusrc_p0;
    assign MemWriteE   = memwrite_p0;
    assign ALUControlE = aluctl_p0;
    assign MemWriteM   = memwrite_p1;
    assign ResultSrcW  = resultsrc_p2;
    assign RegWriteW   = regwrite_p2;
    assign RdW         = rd_p2;
    assign RetireCount = retire_cnt;
    assign StallCount  = stall_cnt;

    // ID -> EX: an all-zero word is a bubble
    always_ff @(posedge clk) begin
        if (rst || flushe) begin
            vld_p0       <= 1'b0;
            jump_p0      <= 1'b0;
            branch_p0    <= 1'b0;
            jalrsrc_p0   <= 1'b0;
            memwrite_p0  <= 1'b0;
            alusrc_p0    <= 1'b0;
            regwrite_p0  <= 1'b0;
            resultsrc_p0 <= 2'b00;
            aluctl_p0    <= 3'b000;
            rs1_p0       <= 5'd0;
            rs2_p0       <= 5'd0;
            rd_p0        <= 5'd0;
        end else begin
            vld_p0       <= ValidD;
            jump_p0      <= JumpD;
            branch_p0    <= BranchD;
            jalrsrc_p0   <= JALRSrcD;
            memwrite_p0  <= MemWriteD;
            alusrc_p0    <= ALUSrcD;
            regwrite_p0  <= RegWriteD;
            resultsrc_p0 <= ResultSrcD;
            aluctl_p0    <= ALUControlD;
            rs1_p0       <= Rs1D;
            rs2_p0       <= Rs2D;
            rd_p0        <= RdD;
        end
    end

    // EX -> MEM -> WB: free-running
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            memwrite_p1  <= 1'b0;
            regwrite_p1  <= 1'b0;
            resultsrc_p1 <= 2'b00;
            rd_p1        <= 5'd0;
            vld_p2       <= 1'b0;
            regwrite_p2  <= 1'b0;
            resultsrc_p2 <= 2'b00;
            rd_p2        <= 5'd0;
        end else begin
            vld_p1       <= vld_p0;
            memwrite_p1  <= memwrite_p0;
            regwrite_p1  <= regwrite_p0;
            resultsrc_p1 <= resultsrc_p0;
            rd_p1        <= rd_p0;
            vld_p2       <= vld_p1;
            regwrite_p2  <= regwrite_p1;
            resultsrc_p2 <= resultsrc_p1;
            rd_p2        <= rd_p1;
        end
    end

    // Performance counters wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (vld_p2) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (lwstall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
